// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: instruction fetch unit feeding a small {pc, inst} queue.
// It issues one instruction-memory read at a time. Redirects flush the queue
// and retarget fetch. A redirect that lands while a read is in flight keeps
// the bus request stable and drops the returned word (DROP state).
// Optional: define IFQ_PERF_EN to add the perf_cnt (pops) and flush_cnt
// (redirects) counter outputs.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        out_ready
`ifdef IFQ_PERF_EN
  ,
  output logic [31:0] perf_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] L_DEPTH = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [31:0] r_fetch_pc;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [31:0] r_q_pc   [DEPTH];
  logic [31:0] r_q_inst [DEPTH];

  logic w_pop;
  logic w_push;
  logic w_can_issue;
  logic w_unused_bits;

  // The low target bits are forced to zero (word alignment), so they are never read.
  assign w_unused_bits = &{1'b0, redirect_pc[1:0]};

  assign w_pop       = (r_count != '0) && out_ready;
  assign w_push      = (r_state == S_REQ) && mem_ack && !redirect_valid;
  // Only one read is ever outstanding and IDLE has none, so count alone bounds occupancy.
  assign w_can_issue = (r_count < L_DEPTH) && !redirect_valid;

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign out_valid = (r_count != '0);
  assign out_pc    = r_q_pc[r_rd_ptr];
  assign out_inst  = r_q_inst[r_rd_ptr];

  // Fetch FSM: issues reads, holds the bus stable until ack, tracks fetch_pc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_can_issue) begin
            r_state    <= S_REQ;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fetch_pc;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
            if (!redirect_valid) begin
              r_fetch_pc <= r_fetch_pc + 32'd4;
            end
          end else if (redirect_valid) begin
            r_state <= S_DROP;
          end
        end
        S_DROP: begin
          if (mem_ack) begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
      // A redirect always retargets fetch; it overrides the +4 above.
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      end
    end
  end

  // Queue occupancy and pointers; a redirect empties the queue outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage; contents need no reset because out_valid gates them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]   <= r_fetch_pc;
      r_q_inst[r_wr_ptr] <= mem_rdata;
    end
  end

`ifdef IFQ_PERF_EN
  logic [31:0] r_perf_cnt;
  logic [31:0] r_flush_cnt;

  assign perf_cnt  = r_perf_cnt;
  assign flush_cnt = r_flush_cnt;

  // Free-running event counters for pops and redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_cnt  <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_pop) begin
        r_perf_cnt <= r_perf_cnt + 32'd1;
      end
      if (redirect_valid) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue: directed table, hand sequences, and a
// randomized run checked every cycle against a queue-based reference model.
module tb_inst_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;
`ifdef IFQ_PERF_EN
  logic [31:0] perf_cnt;
  logic [31:0] flush_cnt;
`endif

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0040_0000)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .out_ready(out_ready)
`ifdef IFQ_PERF_EN
    , .perf_cnt(perf_cnt), .flush_cnt(flush_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t      m_q[$];
  bit          m_busy;
  bit          m_drop;
  logic [31:0] m_req_addr;
  logic [31:0] m_fetch_pc;
  int unsigned m_pops;
  int unsigned m_flushes;

  function automatic void model_reset();
    m_q.delete();
    m_busy     = 1'b0;
    m_drop     = 1'b0;
    m_req_addr = 32'h0;
    m_fetch_pc = 32'h0040_0000;
    m_pops     = 0;
    m_flushes  = 0;
  endfunction

  task automatic model_check();
    check("mem_req", {31'b0, mem_req}, {31'b0, m_busy});
    if (m_busy) check("mem_addr", mem_addr, m_req_addr);
    check("out_valid", {31'b0, out_valid}, (m_q.size() != 0) ? 32'd1 : 32'd0);
    if (m_q.size() != 0) begin
      check("out_pc", out_pc, m_q[0].pc);
      check("out_inst", out_inst, m_q[0].inst);
    end
`ifdef IFQ_PERF_EN
    check("perf_cnt", perf_cnt, m_pops);
    check("flush_cnt", flush_cnt, m_flushes);
`endif
  endtask

  // One clock of behaviour: pop, complete/drop/issue a read, then flush on redirect.
  function automatic void model_step();
    bit can_issue;
    can_issue = !m_busy && (m_q.size() < DEPTH) && !redirect_valid;
    if (out_ready && m_q.size() != 0) begin
      void'(m_q.pop_front());
      m_pops++;
    end
    if (m_busy && mem_ack) begin
      if (!m_drop && !redirect_valid) begin
        m_q.push_back('{pc: m_req_addr, inst: mem_rdata});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      m_busy = 1'b0;
      m_drop = 1'b0;
    end else if (m_busy && redirect_valid) begin
      m_drop = 1'b1;
    end else if (can_issue) begin
      m_busy     = 1'b1;
      m_req_addr = m_fetch_pc;
    end
    if (redirect_valid) begin
      m_q.delete();
      m_fetch_pc = {redirect_pc[31:2], 2'b00};
      m_flushes++;
    end
  endfunction

  // ---------------- cycle helpers ----------------
  bit auto_ack = 1'b0;
  int ack_pct  = 100;
  bit man_ack  = 1'b0;

  task automatic tick_begin();
    @(negedge clk);
    mem_rdata = $urandom;
    mem_ack   = auto_ack ? (mem_req && ($urandom_range(99) < ack_pct)) : man_ack;
    #1;
    model_check();
  endtask

  task automatic tick_end();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    tick_begin();
    tick_end();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
`ifdef IFQ_PERF_EN
    check("rst_perf_cnt", perf_cnt, 32'd0);
    check("rst_flush_cnt", flush_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit        redir;
    bit        ready;
    bit        ack;
    bit        exp_req;
    bit [31:0] exp_addr;
    bit        exp_valid;
    bit [31:0] exp_pc;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acks;
    // Reset release, single-cycle memory, decode always ready.
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0040_0000, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0040_0000};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0040_0004, 1'b0, 32'h0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0040_0004};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0040_0008, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0040_0008};

    #2;
    do_reset();
    auto_ack = 1'b0;
    for (int i = 0; i < 7; i++) begin
      redirect_valid = tbl[i].redir;
      out_ready      = tbl[i].ready;
      man_ack        = tbl[i].ack;
      tick_begin();
      check($sformatf("t034_req[%0d]", i), {31'b0, mem_req}, {31'b0, tbl[i].exp_req});
      if (tbl[i].exp_req) check($sformatf("t034_addr[%0d]", i), mem_addr, tbl[i].exp_addr);
      check($sformatf("t034_valid[%0d]", i), {31'b0, out_valid}, {31'b0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) check($sformatf("t034_pc[%0d]", i), out_pc, tbl[i].exp_pc);
      tick_end();
      $display("t034 vec %0d req=%0b addr=%08h valid=%0b pc=%08h", i, mem_req, mem_addr, out_valid, out_pc);
    end
    man_ack = 1'b0;

    // Decode stalled: queue fills to DEPTH, then one pop reopens fetch.
    do_reset();
    auto_ack = 1'b1; ack_pct = 100; out_ready = 1'b0;
    acks = 0;
    repeat (14) begin
      tick_begin();
      if (mem_ack) acks++;
      tick_end();
    end
    check("t035_pushes", acks, 32'd4);
    tick_begin();
    check("t035_req_full", {31'b0, mem_req}, 32'd0);
    check("t035_valid_full", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick_end();
    out_ready = 1'b0;
    cyc();
    tick_begin();
    check("t035_req_after_pop", {31'b0, mem_req}, 32'd1);
    check("t035_addr_after_pop", mem_addr, 32'h0040_0010);
    tick_end();
    $display("t035 pushes=%0d next_addr=%08h", acks, mem_addr);

    // Redirect with 3 entries queued.
    do_reset();
    auto_ack = 1'b1; ack_pct = 100; out_ready = 1'b0;
    repeat (6) cyc();
    tick_begin();
    check("t036_valid_before", {31'b0, out_valid}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0103;
    tick_end();
    redirect_valid = 1'b0;
    tick_begin();
    check("t036_valid_after", {31'b0, out_valid}, 32'd0);
    tick_end();
    tick_begin();
    check("t036_req", {31'b0, mem_req}, 32'd1);
    check("t036_addr", mem_addr, 32'h0040_0100);
    tick_end();
    $display("t036 redirect addr=%08h", mem_addr);

    // Redirect while a read is waiting; ack arrives 3 cycles later.
    do_reset();
    auto_ack = 1'b0; man_ack = 1'b0; out_ready = 1'b1;
    cyc();
    tick_begin();
    check("t037_req", {31'b0, mem_req}, 32'd1);
    check("t037_addr", mem_addr, 32'h0040_0000);
    redirect_valid = 1'b1; redirect_pc = 32'h0050_0000;
    tick_end();
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) man_ack = 1'b1;
      tick_begin();
      check($sformatf("t037_hold_req[%0d]", k), {31'b0, mem_req}, 32'd1);
      check($sformatf("t037_hold_addr[%0d]", k), mem_addr, 32'h0040_0000);
      tick_end();
    end
    man_ack = 1'b0;
    tick_begin();
    check("t037_no_push", {31'b0, out_valid}, 32'd0);
    check("t037_idle", {31'b0, mem_req}, 32'd0);
    tick_end();
    tick_begin();
    check("t037_new_addr", mem_addr, 32'h0050_0000);
    tick_end();
    $display("t037 drop done next_addr=%08h", mem_addr);

    // Redirect coincident with ack and a pop.
    do_reset();
    auto_ack = 1'b0; man_ack = 1'b0; out_ready = 1'b0;
    cyc();
    man_ack = 1'b1;
    cyc();
    man_ack = 1'b0;
    cyc();
    man_ack = 1'b1;
    tick_begin();
    check("t038_req", {31'b0, mem_req}, 32'd1);
    check("t038_addr", mem_addr, 32'h0040_0004);
    check("t038_valid", {31'b0, out_valid}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0060_0008; out_ready = 1'b1;
    tick_end();
    redirect_valid = 1'b0; out_ready = 1'b0; man_ack = 1'b0;
    tick_begin();
    check("t038_flushed", {31'b0, out_valid}, 32'd0);
    check("t038_idle", {31'b0, mem_req}, 32'd0);
    tick_end();
    tick_begin();
    check("t038_resume", mem_addr, 32'h0060_0008);
    tick_end();
    $display("t038 resume addr=%08h", mem_addr);

    // Ack while idle after reset is ignored; then reset mid-request.
    do_reset();
    auto_ack = 1'b0; man_ack = 1'b1; out_ready = 1'b0;
    cyc();
    man_ack = 1'b0;
    cyc();
    tick_begin();
    check("t030_no_push", {31'b0, out_valid}, 32'd0);
    check("t030_req", {31'b0, mem_req}, 32'd1);
    do_reset();
    $display("t030 stray ack ignored, async reset mid-request");

`ifdef IFQ_PERF_EN
    // Counter check: 10 pops, 2 redirects, then async reset mid-request.
    auto_ack = 1'b1; ack_pct = 100; out_ready = 1'b1;
    for (int n = 0; n < 200 && m_pops < 10; n++) cyc();
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0070_0000;
    cyc();
    cyc();
    redirect_valid = 1'b0;
    auto_ack = 1'b0; man_ack = 1'b0;
    tick_begin();
    check("t039_perf", perf_cnt, 32'd10);
    check("t039_flush", flush_cnt, 32'd2);
    tick_end();
    tick_begin();
    check("t039_req", {31'b0, mem_req}, 32'd1);
    do_reset();
    $display("t039 perf counters checked");
`endif

    // Randomized run against the model, including targets near the top of memory.
    do_reset();
    auto_ack = 1'b1; ack_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      out_ready      = ($urandom_range(3) != 0);
      redirect_valid = ($urandom_range(15) == 0);
      redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      if ($urandom_range(499) == 0) begin
        do_reset();
      end else begin
        cyc();
      end
      if (i % 500 == 0) $display("rand cycle %0d checks=%0d errors=%0d", i, checks, errors);
    end
    redirect_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
